// File: rtl/prog_encoder_rom_if.sv
// Field-bundle handshake between an instruction producer and the encoder ROM.
// The master drives decoded fields; the slave reports readiness.
interface prog_encoder_rom_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [2:0] in_wr;
  logic [2:0] in_rd_b;
  logic [2:0] in_rd_a;
  logic       in_nop;
  logic       in_last;

  modport master (
    output in_valid, in_op, in_wr, in_rd_b, in_rd_a, in_nop, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_wr, in_rd_b, in_rd_a, in_nop, in_last,
    output in_ready
  );
endinterface

// File: rtl/prog_encoder_rom.sv
// Packs decoded instruction fields into 16-bit words, stores them, then serves
// them on the mproc fetch port while holding the core in reset during loading.
module prog_encoder_rom #(
  parameter int          AW       = 4,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic                    clk,
  input  logic                    reset,
  prog_encoder_rom_if.slave       bus,
  input  logic                    restart,
  input  logic [15:0]             addr,
  output logic [15:0]             ins,
  output logic                    cpu_hold,
  output logic [AW:0]             count,
  output logic                    loading
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

  typedef enum logic {LOAD, RUN} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] mem [DEPTH];
  logic        transfer;
  logic [15:0] packed_word;
  logic [15:0] count_wide;

  assign bus.in_ready = (state == LOAD);
  assign loading      = (state == LOAD);
  assign cpu_hold     = (state == LOAD);

  assign transfer    = bus.in_valid && (state == LOAD);
  assign packed_word = {(bus.in_nop ? 5'b00001 : 5'b00000),
                        bus.in_op, bus.in_wr, bus.in_rd_b, bus.in_rd_a};
  assign count_wide  = 16'(count);

  always_ff @(posedge clk) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  // Leaving LOAD on the final bundle or on the one that fills memory means
  // the memory can never wrap.
  always_comb begin
    state_next = state;
    case (state)
      LOAD: if (transfer && (bus.in_last || count == LAST_IDX)) state_next = RUN;
      RUN:  if (restart) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)                       count <= '0;
    else if (state == RUN && restart) count <= '0;
    else if (transfer)                count <= count + 1'b1;
  end

  // Contents survive reset; count masks anything not loaded in this program.
  always_ff @(posedge clk) begin
    if (reset && transfer) mem[count[AW-1:0]] <= packed_word;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      ins <= NOP_WORD;
    else if (state == RUN && !restart && addr < count_wide)
      ins <= mem[addr[AW-1:0]];
    else
      ins <= NOP_WORD;
  end

endmodule

// File: tb/tb_prog_encoder_rom.sv
// Scoreboard bench for prog_encoder_rom: loads programs, fetches words and
// compares against a behavioural model of the load/run protocol.
module tb_prog_encoder_rom;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] NOP   = 16'h0800;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] ins;
  logic        cpu_hold;
  logic        loading;
  logic [AW:0] count;

  prog_encoder_rom_if bus ();

  prog_encoder_rom #(.AW(AW), .NOP_WORD(NOP)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .restart  (restart),
    .addr     (addr),
    .ins      (ins),
    .cpu_hold (cpu_hold),
    .count    (count),
    .loading  (loading)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_mem [DEPTH];
  int          model_count = 0;
  logic        model_loading = 1'b1;
  logic [15:0] exp_q [$];

  function automatic logic [15:0] pack_word(input logic [1:0] op, input logic [2:0] wr,
                                            input logic [2:0] rdb, input logic [2:0] rda,
                                            input logic nop);
    return {(nop ? 5'b00001 : 5'b00000), op, wr, rdb, rda};
  endfunction

  function automatic logic [15:0] model_fetch(input logic [15:0] a);
    if (model_loading || int'(a) >= model_count) return NOP;
    return model_mem[a[AW-1:0]];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, ".count"},    32'(count),    32'(model_count));
    checkOutput({tag, ".loading"},  32'(loading),  32'(model_loading));
    checkOutput({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(model_loading));
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(model_loading));
  endtask

  // Drives one bundle for one cycle; in_valid stays high so callers can go back-to-back.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] wr, input logic [2:0] rdb,
                               input logic [2:0] rda, input logic nop, input logic last);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_wr    = wr;
    bus.in_rd_b  = rdb;
    bus.in_rd_a  = rda;
    bus.in_nop   = nop;
    bus.in_last  = last;
    if (model_loading) begin
      model_mem[model_count] = pack_word(op, wr, rdb, rda, nop);
      model_count++;
      if (last || model_count == DEPTH) model_loading = 1'b0;
    end
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
  endtask

  task automatic fetch_expect(input logic [15:0] a, input logic [15:0] expected);
    addr = a;
    exp_q.push_back(expected);
    tick();
    checkOutput($sformatf("ins@%0h", a), 32'(ins), 32'(exp_q.pop_front()));
  endtask

  task automatic fetch_word(input logic [15:0] a);
    fetch_expect(a, model_fetch(a));
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_count   = 0;
    model_loading = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_wr    = '0;
    bus.in_rd_b  = '0;
    bus.in_rd_a  = '0;
    bus.in_nop   = 1'b0;
    bus.in_last  = 1'b0;

    // Reset and hold
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_state("reset");
    checkOutput("reset.ins", 32'(ins), 32'(NOP));
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold.count", 32'(count), 32'd0);
      checkOutput("hold.cpu_hold", 32'(cpu_hold), 32'd1);
    end
    check_state("hold");
    checkOutput("hold.ins", 32'(ins), 32'(NOP));

    // restart is ignored in LOAD
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_state("restart_in_load");

    // Three-instruction program
    applyStimulus(2'd2, 3'd5, 3'd3, 3'd1, 1'b0, 1'b0);
    check_state("load0");
    applyStimulus(2'd1, 3'd7, 3'd0, 3'd6, 1'b0, 1'b0);
    check_state("load1");
    checkOutput("load.ins", 32'(ins), 32'(NOP));
    applyStimulus(2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_state("load2");
    checkOutput("run.count3", 32'(count), 32'd3);
    fetch_expect(16'd0, 16'h0559);
    fetch_expect(16'd1, 16'h03C6);
    fetch_expect(16'd2, 16'h0800);
    fetch_expect(16'd3, NOP);
    fetch_expect(16'h0010, NOP);

    // Full memory without in_last
    do_restart();
    check_state("restart");
    fetch_expect(16'd0, NOP);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(2'(i >> 2), 3'(i ^ 5), 3'(i + 1), 3'(i), 1'b0, 1'b0);
      checkOutput("full.count", 32'(count), 32'(i + 1));
    end
    check_state("full");
    applyStimulus(2'd3, 3'd7, 3'd7, 3'd7, 1'b0, 1'b1);
    idle();
    check_state("full17");
    checkOutput("full17.count", 32'(count), 32'd16);
    fetch_expect(16'd15, pack_word(2'd3, 3'd2, 3'd0, 3'd7, 1'b0));
    for (int a = 0; a < DEPTH; a++) fetch_word(16'(a));
    fetch_word(16'h8003);

    // Stall tolerance
    do_restart();
    for (int i = 0; i < 4; i++) begin
      idle();
      applyStimulus(2'(i), 3'(7 - i), 3'(i + 2), 3'(i + 4), 1'(i & 1), (i == 3) ? 1'b1 : 1'b0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    idle();
    check_state("stall");
    checkOutput("stall.count", 32'(count), 32'd4);
    for (int a = 0; a < 5; a++) fetch_word(16'(a));

    // Restart and reset mid-load
    do_restart();
    check_state("restart2");
    fetch_expect(16'd0, NOP);
    applyStimulus(2'd1, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
    applyStimulus(2'd2, 3'd2, 3'd2, 3'd2, 1'b0, 1'b0);
    check_state("midload");
    reset = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    model_count   = 0;
    model_loading = 1'b1;
    check_state("midreset");
    checkOutput("midreset.ins", 32'(ins), 32'(NOP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_encoder_rom.md
Name: prog_encoder_rom

Overview:
- Writer/encoder side of the instruction interface consumed by the three-phase mproc core: accepts decoded instruction fields over a valid/ready handshake and packs them into the 16-bit instruction format.
- Stores the packed instructions in a small program memory, then serves them on the core's fetch interface (addr in, ins out).
- Holds the core in reset while a program loads and releases it when loading completes.

Parameters:
- AW, 4, program memory address width; depth = 2**AW entries.
- NOP_WORD, 16'h0800, word served for unloaded or out-of-range addresses; bits [15:11] are nonzero, so the core performs no register write.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  block can accept a bundle
- in_op  input  2  ALU op, packed to ins[10:9]
- in_wr  input  3  write register address, packed to ins[8:6]
- in_rd_b  input  3  read port B address, packed to ins[5:3]
- in_rd_a  input  3  read port A address, packed to ins[2:0]
- in_nop  input  1  1 = emit a no-write instruction (ins[15:11] = 5'b00001)
- in_last  input  1  this bundle is the final instruction of the program
- restart  input  1  in RUN: return to LOAD and discard the program
- addr  input  16  fetch address from the core's PC
- ins  output  16  registered instruction word to the core
- cpu_hold  output  1  1 = hold the core in reset
- count  output  AW+1  number of instructions loaded
- loading  output  1  1 in the LOAD state

Behaviour:
- Reset is synchronous and active-low: when reset = 0 at a clk edge:
  - state <= LOAD, count <= 0, ins <= NOP_WORD, cpu_hold <= 1.
  - Memory contents are not cleared. Unloaded entries are masked by count.
  - Reset mid-load or mid-run aborts the operation with no partial effects.
- States: LOAD and RUN.
- LOAD state:
  - in_ready = 1, loading = 1, cpu_hold = 1.
  - A transfer occurs on a clk edge with in_valid & in_ready.
  - On a transfer: mem[count] <= {in_nop ? 5'b00001 : 5'b00000, in_op, in_wr, in_rd_b, in_rd_a}, and count <= count + 1.
  - Transition to RUN after the transfer when in_last = 1, or when count reaches 2**AW (the memory is full).
  - The memory never wraps. No bundle is accepted after it is full, because the state has already left LOAD.
  - in_valid = 0 leaves all state unchanged.
  - ins is held at NOP_WORD throughout LOAD.
- RUN state:
  - in_ready = 0, loading = 0, cpu_hold = 0. in_valid is ignored.
  - cpu_hold falls on the same edge that enters RUN.
  - Each cycle: ins <= mem[addr[AW-1:0]] when addr < count; otherwise ins <= NOP_WORD. addr >= count covers any nonzero addr[15:AW].
  - Read latency is 1 clk. This fits the core's fetch, because load_ir is asserted the cycle after pc_inc.
- restart in RUN, synchronous:
  - Next state is LOAD, count <= 0, cpu_hold <= 1, ins <= NOP_WORD.
  - restart is ignored in LOAD.
- Simultaneous events:
  - reset has priority over restart and over transfers.
  - If in_last = 1 and the transfer also fills the memory, the block enters RUN once, with count = 2**AW.
  - A bundle with in_last = 1 as the first transfer gives count = 1.
- in_last with in_valid = 0 has no effect.
- Field packing is purely positional; no field value is checked or rejected.
- Outputs in_ready, loading and cpu_hold are decoded from the registered state only, so there is no combinational path from inputs to outputs.

Test Plan:
- Reset and hold: reset = 0 for 2 cycles, then 1, with in_valid = 0 -> count = 0, cpu_hold = 1, in_ready = 1, ins = 16'h0800; stays so for 10 cycles.
- Pack and serve 3 instructions:
  - Load {op=2, wr=5, rd_b=3, rd_a=1, nop=0}, then {op=1, wr=7, rd_b=0, rd_a=6, nop=0}, then {nop=1, all fields 0, last=1}.
  - Required: RUN entered the cycle after the third transfer, count = 3.
  - addr = 0, 1, 2 -> ins = 16'h0559, 16'h03C6, 16'h0800, each one clk later.
- Out-of-range fetch: with the program above, addr = 3 and addr = 16'h0010 -> ins = 16'h0800.
- Full memory, no in_last: 16 back-to-back transfers with a value i in each rd_a field -> RUN after the 16th transfer, count = 16. A 17th in_valid is not accepted and count stays 16. addr = 15 returns the 16th word.
- Stall tolerance: toggle in_valid every other cycle over 4 transfers -> exactly 4 words stored, count = 4, contents match.
- Restart and reset mid-load:
  - restart = 1 in RUN -> next cycle loading = 1, cpu_hold = 1, count = 0, addr = 0 gives ins = 16'h0800.
  - After 2 new transfers, reset = 0 -> count = 0, state LOAD.
